// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and the
// default bit period used by the rx (and tx) blocks.
package uart_pkg;

  localparam int   UART_DATA_BITS    = 8;
  localparam logic UART_IDLE_LEVEL   = 1'b1;
  localparam int   UART_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte-level handshake between uart_rx (master) and its consumer (slave).
interface uart_rx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] rx_byte;
  logic                      rx_valid;
  logic                      rx_ack;
  logic                      rx_receiving;
  logic                      rx_frame_err;
  logic                      rx_overrun;
  logic                      rx_parity_err;

  modport master (
    output rx_byte, rx_valid, rx_receiving, rx_frame_err, rx_overrun, rx_parity_err,
    input  rx_ack
  );

  modport slave (
    input  rx_byte, rx_valid, rx_receiving, rx_frame_err, rx_overrun, rx_parity_err,
    output rx_ack
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input; both flops reset to
// RESET_VAL so the output comes up at the line's idle level.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // NOTE: clocked state uses non-blocking assignments so both flops sample
  // the pre-edge values; blocking here would collapse the chain to one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8-bit oversampling UART receiver with a one-entry holding register.
// Define UART_RX_PARITY_EN for 8E1 frames (even-parity bit after bit 7).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx_input,
  uart_rx_if.master    bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
  localparam rx_state_e AFTER_DATA = RX_PARITY;
`else
  localparam rx_state_e AFTER_DATA = RX_STOP;
`endif

  logic                      rxs;
  rx_state_e                 state_q;
  logic [CW-1:0]             cnt_q;
  logic [2:0]                idx_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [UART_DATA_BITS-1:0] byte_q;
  logic                      valid_q;
  logic                      receiving_q;
  logic                      frame_err_q;
  logic                      overrun_q;
  logic                      bit_end;
  logic                      ack_take;

  uart_rx_sync #(
    .RESET_VAL (UART_IDLE_LEVEL)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx_input),
    .q_o   (rxs)
  );

  assign bit_end  = (cnt_q == CNT_FULL);
  assign ack_take = bus.rx_ack && valid_q;

`ifdef UART_RX_PARITY_EN
  logic parity_err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      byte_q      <= '0;
      valid_q     <= 1'b0;
      receiving_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      // NOTE: the consumer ack is applied first; a delivery further down in
      // the same cycle overrides valid_q, so delivery wins over ack.
      if (ack_take) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end

      case (state_q)
        RX_IDLE: begin
          if (!rxs) begin
            state_q <= RX_START;
            cnt_q   <= '0;
          end
        end

        RX_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q <= '0;
            if (!rxs) begin
              state_q     <= RX_DATA;
              idx_q       <= '0;
              receiving_q <= 1'b1;
            end else begin
              state_q <= RX_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        RX_DATA: begin
          if (bit_end) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rxs;
            idx_q          <= idx_q + 3'd1;
            if (idx_q == 3'd7) state_q <= AFTER_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          if (bit_end) begin
            cnt_q        <= '0;
            parity_err_q <= (rxs != even_parity(shift_q));
            state_q      <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`endif

        RX_STOP: begin
          if (bit_end) begin
            cnt_q       <= '0;
            receiving_q <= 1'b0;
            if (rxs) begin
              state_q <= RX_IDLE;
              byte_q  <= shift_q;
              valid_q <= 1'b1;
              if (valid_q && !bus.rx_ack) overrun_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= RX_WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        // A held-low (break) line must return high before a new start counts.
        RX_WAIT_HIGH: begin
          if (rxs) state_q <= RX_IDLE;
        end

        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign bus.rx_byte      = byte_q;
  assign bus.rx_valid     = valid_q;
  assign bus.rx_receiving = receiving_q;
  assign bus.rx_frame_err = frame_err_q;
  assign bus.rx_overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign bus.rx_parity_err = parity_err_q;
`else
  assign bus.rx_parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver: the receive end of the team's 8-bit UART link. It oversamples a single `rx_input` line, recovers start/data/stop framing (LSB first, idle-high), and presents each received byte through a one-entry holding register with a valid/ack handshake. It sits between the board pin and the byte-level consumer logic, mirroring the existing transmitter.

## Interface
- `CLKS_PER_BIT`, 16: `clk` cycles per serial bit; legal range 4..65535.
- `clk`  input  1  system clock; all logic on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `rx_input`  input  1  serial line, asynchronous to `clk`; idle high.
- `rx_ack`  input  1  consumer has taken `rx_byte`; clears `rx_valid`.
- `rx_byte`  output  8  last received byte; stable while `rx_valid`=1.
- `rx_valid`  output  1  holding register full.
- `rx_receiving`  output  1  high from start-bit confirmation until the stop-bit sample.
- `rx_frame_err`  output  1  one-cycle pulse: stop bit sampled low.
- `rx_overrun`  output  1  sticky: a frame completed while `rx_valid`=1; cleared by `rx_ack`.
- `rx_parity_err`  output  1  one-cycle pulse, parity mismatch (tied 0 without `UART_RX_PARITY_EN`).

## Operation
- Input path: 2-flop synchronizer on `rx_input`; synchronizer flops reset to 1. All FSM decisions use the synchronized signal `rxs`.
- Bit counter `cnt` width `$clog2(CLKS_PER_BIT)`; data index `idx` 3 bits.
- States:
  - IDLE: `rxs`=0 -> START, `cnt`<=0.
  - START: at `cnt`=CLKS_PER_BIT/2-1 sample `rxs`; 0 -> DATA (`cnt`<=0, `idx`<=0); 1 -> IDLE (glitch rejected, no flags).
  - DATA: at `cnt`=CLKS_PER_BIT-1 shift `rxs` into bit `idx`; after `idx`=7 -> PARITY if enabled, else STOP.
  - PARITY: sample at full bit period; compare to even parity of the shift register.
  - STOP: sample at full bit period. 1 -> deliver, IDLE. 0 -> pulse `rx_frame_err`, discard byte, WAIT_HIGH.
  - WAIT_HIGH: remain until `rxs`=1, then IDLE (break condition never retriggers a start).
- Deliver: `rx_byte`<=shift register, `rx_valid`<=1. If `rx_valid` was already 1: `rx_byte` overwritten with new byte, `rx_overrun`<=1.
- Parity error: pulse `rx_parity_err`, byte still delivered.
- `rx_ack` with `rx_valid`=1 clears `rx_valid` and `rx_overrun` next cycle. Deliver and `rx_ack` in the same cycle: delivery wins, `rx_valid` stays 1, `rx_overrun` cleared (old byte was consumed).
- `rx_ack` while `rx_valid`=0: ignored.

## Timing
- Reset values: `rx_byte`=0, `rx_valid`=0, `rx_receiving`=0, `rx_frame_err`=0, `rx_overrun`=0, `rx_parity_err`=0, state IDLE.
- Reset asserted mid-frame: all of the above immediately; partial byte lost. After release, a line already low is treated as a start edge only after it is seen high first (synchronizer resets high, so a held-low line enters START; it then fails at the stop bit -> WAIT_HIGH, acceptable and required).
- Latency: line falling edge -> START entry = 3 cycles (2 sync + 1). Stop-bit sample -> `rx_valid` high next cycle.
- Total frame: 10 (11 with parity) bit periods; a new start bit is accepted in the cycle after the stop sample, i.e. half a stop bit of tolerance for back-to-back frames.
- Tolerated clock mismatch: ±4% at CLKS_PER_BIT≥8.

## Configuration
- `UART_RX_PARITY_EN` defined: frame carries an even-parity bit after data bit 7; PARITY state and `rx_parity_err` active.
- Not defined: no PARITY state; frame is 8N1, matching the existing transmitter; `rx_parity_err` tied 0.

## Structure
- Shared `uart_pkg`: state enum (`RX_IDLE`, `RX_START`, `RX_DATA`, `RX_PARITY`, `RX_STOP`, `RX_WAIT_HIGH`), constants `UART_DATA_BITS`=8, `UART_IDLE_LEVEL`=1, default `CLKS_PER_BIT`.
- Sub-module `uart_rx_sync`: 2-flop synchronizer with reset value parameter; reused by future input paths.

## Test plan
- 8N1 frame 0xA5 at CLKS_PER_BIT=16 -> `rx_byte`=0xA5, `rx_valid`=1 one cycle after stop sample, no error flags.
- 3-cycle low glitch on idle line -> returns IDLE, `rx_receiving` never asserts, `rx_valid` stays 0.
- Frame 0x3C with stop bit forced 0, line held low 40 cycles -> one `rx_frame_err` pulse, `rx_valid`=0, no restart until line high.
- Frames 0x11 then 0x22 back-to-back without `rx_ack` -> `rx_byte`=0x22, `rx_overrun`=1; `rx_ack` -> both cleared.
- Reset pulse at data bit 4 of 0xFF -> all outputs 0 immediately; following frame 0x5A received correctly.
- `UART_RX_PARITY_EN`: 0x07 with parity 0 -> `rx_parity_err` pulse, `rx_byte`=0x07; with parity 1 -> no error.
